// File: rtl/avalon_flash_read_responder.sv
// Avalon-MM byte read responder over a preloadable 2^ADDR_W x 8 memory, with wait states.
// Define RANDOM_WAIT_EN to draw each read's wait count from an LFSR instead of WAIT_CYCLES.
module avalon_flash_read_responder #(
   parameter int ADDR_W      = 8,
   parameter int WAIT_CYCLES = 3,
   parameter int CNT_W       = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] address,
   input  logic              read,
   output logic              waitrequest,
   output logic [7:0]        readdata,
   input  logic              ld_we,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [7:0]        ld_data,
   output logic              busy,
   output logic [CNT_W-1:0]  read_count
);

   typedef enum logic [1:0] {IDLE, WAIT, LOAD, RESP} state_t;

   state_t            state, state_nxt;
   logic [7:0]        wcnt, wcnt_nxt;
   logic [7:0]        accept_cnt;
   logic [ADDR_W-1:0] addr_r;
   logic [7:0]        mem [0:(1<<ADDR_W)-1];

`ifdef RANDOM_WAIT_EN
   localparam logic [8:0] WAIT_MOD = 9'(WAIT_CYCLES + 1);

   logic [7:0] lfsr;
   logic [8:0] lfsr_mod;

   // Fibonacci taps 8,6,5,4; free-running so back-to-back reads see different draws
   always_ff @(posedge clk) begin
      if (!rst_n) lfsr <= 8'hA5;
      else        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   end

   assign lfsr_mod   = {1'b0, lfsr} % WAIT_MOD;
   assign accept_cnt = lfsr_mod[7:0];
`else
   assign accept_cnt = 8'(WAIT_CYCLES);
`endif

   always_comb begin
      state_nxt = state;
      wcnt_nxt  = wcnt;
      case (state)
         IDLE: begin
            if (read) begin
               wcnt_nxt  = accept_cnt;
               state_nxt = (accept_cnt == 8'd0) ? LOAD : WAIT;
            end
         end
         WAIT: begin
            if (!read) begin
               state_nxt = IDLE;
            end else begin
               wcnt_nxt = wcnt - 8'd1;
               if (wcnt <= 8'd1) state_nxt = LOAD;
            end
         end
         LOAD:    state_nxt = read ? RESP : IDLE;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         wcnt       <= 8'd0;
         addr_r     <= '0;
         readdata   <= 8'h00;
         read_count <= '0;
      end else begin
         state <= state_nxt;
         wcnt  <= wcnt_nxt;
         if (state == IDLE && read) addr_r <= address;
         // Nonblocking read of mem gives read-before-write against a same-edge preload
         if (state == LOAD && read) readdata <= mem[addr_r];
         if (state == RESP) read_count <= read_count + CNT_W'(1);
      end
   end

   // Preload port: contents deliberately survive reset
   always_ff @(posedge clk) begin
      if (ld_we) mem[ld_addr] <= ld_data;
   end

   assign waitrequest = (state != RESP);
   assign busy        = (state != IDLE);

endmodule

// File: tb/tb_avalon_flash_read_responder.sv
// Directed bench for avalon_flash_read_responder; expected read data flows through a scoreboard queue.
module tb_avalon_flash_read_responder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  address, ld_addr, ld_data;
   logic        ld_we;
   logic        rd3, rd0, rd7;
   logic        wr3, wr0, wr7;
   logic [7:0]  rdata3, rdata0, rdata7;
   logic        busy3, busy0, busy7;
   logic [15:0] cnt3, cnt7;
   logic [1:0]  cnt0;

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  sb[$];
   int          exp_cnt3 = 0, exp_cnt0 = 0, exp_cnt7 = 0;

   always #5 clk = ~clk;

   avalon_flash_read_responder #(.ADDR_W(8), .WAIT_CYCLES(3), .CNT_W(16)) dut3 (
      .clk(clk), .rst_n(rst_n), .address(address), .read(rd3), .waitrequest(wr3),
      .readdata(rdata3), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
      .busy(busy3), .read_count(cnt3));

   avalon_flash_read_responder #(.ADDR_W(8), .WAIT_CYCLES(0), .CNT_W(2)) dut0 (
      .clk(clk), .rst_n(rst_n), .address(address), .read(rd0), .waitrequest(wr0),
      .readdata(rdata0), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
      .busy(busy0), .read_count(cnt0));

   avalon_flash_read_responder #(.ADDR_W(8), .WAIT_CYCLES(7), .CNT_W(16)) dut7 (
      .clk(clk), .rst_n(rst_n), .address(address), .read(rd7), .waitrequest(wr7),
      .readdata(rdata7), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
      .busy(busy7), .read_count(cnt7));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic wr_of(input int w);
      case (w)
         0:       return wr0;
         3:       return wr3;
         default: return wr7;
      endcase
   endfunction

   function automatic logic [7:0] data_of(input int w);
      case (w)
         0:       return rdata0;
         3:       return rdata3;
         default: return rdata7;
      endcase
   endfunction

   task automatic set_rd(input int w, input logic v);
      case (w)
         0:       rd0 = v;
         3:       rd3 = v;
         default: rd7 = v;
      endcase
   endtask

   task automatic ld(input logic [7:0] a, input logic [7:0] d);
      ld_addr = a; ld_data = d; ld_we = 1'b1;
      @(negedge clk);
      ld_we = 1'b0;
   endtask

   // lat counts rising edges from the first one that samples read up to the ack cycle
   task automatic do_read(input int w, input logic [7:0] a, input logic [7:0] exp_d,
                          input int chg_cyc, input logic [7:0] chg_a,
                          input int ld_cyc, input logic [7:0] ld_d, output int lat);
      logic [7:0] e;
      bit acked;
      acked = 1'b0;
      @(negedge clk);
      sb.push_back(exp_d);
      address = a;
      set_rd(w, 1'b1);
      lat = 0;
      while (lat < 300) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         ld_we = (lat == ld_cyc);
         if (lat == ld_cyc) begin ld_addr = a; ld_data = ld_d; end
         if (lat == chg_cyc) address = chg_a;
         if (!wr_of(w)) begin acked = 1'b1; break; end
      end
      e = sb.pop_front();
      if (acked) check($sformatf("rdata%0d@%02h", w, a), 32'(data_of(w)), 32'(e));
      else       check($sformatf("ack_timeout%0d", w), 32'(acked), 32'(1));
      set_rd(w, 1'b0);
   endtask

   initial begin
      int lat, acks, cyc, last, lowseen, nlat;
      logic [7:0] e, a;
      bit [15:0] seen;

      rst_n = 1'b0; address = '0; ld_we = 1'b0; ld_addr = '0; ld_data = '0;
      rd3 = 1'b0; rd0 = 1'b0; rd7 = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_wr", 32'(wr3), 32'(1));
      check("rst_busy", 32'(busy3), 32'(0));
      check("rst_rdata", 32'(rdata3), 32'(0));
      check("rst_cnt", 32'(cnt3), 32'(0));
      check("rst_cnt0", 32'(cnt0), 32'(0));
      rst_n = 1'b1;

      ld(8'h10, 8'h5A); ld(8'h00, 8'hC3); ld(8'h01, 8'h11); ld(8'h02, 8'h22);
      ld(8'h03, 8'h33); ld(8'h04, 8'hAA); ld(8'h05, 8'h55); ld(8'h06, 8'h66);

`ifndef RANDOM_WAIT_EN
      do_read(3, 8'h10, 8'h5A, -1, 8'h00, -1, 8'h00, lat);
      check("lat_w3", 32'(lat), 32'(5));
      exp_cnt3++;
      @(negedge clk);
      check("cnt_after1", 32'(cnt3), 32'(exp_cnt3));
      check("wr_after_ack", 32'(wr3), 32'(1));
      @(negedge clk);
      check("rdata_hold", 32'(rdata3), 32'(8'h5A));
      check("busy_idle", 32'(busy3), 32'(0));
`endif

      do_read(0, 8'h00, 8'hC3, -1, 8'h00, -1, 8'h00, lat);
      check("lat_w0", 32'(lat), 32'(2));
      exp_cnt0++;
      @(negedge clk);
      check("cnt0_after1", 32'(cnt0), 32'(exp_cnt0 % 4));

`ifndef RANDOM_WAIT_EN
      // Back-to-back with read held: each ack is one cycle, spaced WAIT_CYCLES+3 apart
      sb.push_back(8'h11); sb.push_back(8'h22); sb.push_back(8'h33);
      address = 8'h01; rd3 = 1'b1; acks = 0; cyc = 0; last = 0;
      while (acks < 3 && cyc < 200) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         if (!wr3) begin
            e = sb.pop_front();
            check($sformatf("b2b_data%0d", acks), 32'(rdata3), 32'(e));
            if (acks > 0) check("b2b_gap", 32'(cyc - last), 32'(6));
            last = cyc;
            acks++;
            address = 8'h01 + 8'(acks);
            if (acks == 3) rd3 = 1'b0;
         end
      end
      rd3 = 1'b0;
      sb.delete();
      check("b2b_acks", 32'(acks), 32'(3));
      exp_cnt3 += 3;
      @(negedge clk);
      check("cnt_b2b", 32'(cnt3), 32'(exp_cnt3));

      do_read(3, 8'h04, 8'hAA, 2, 8'h05, -1, 8'h00, lat);
      check("lat_chg", 32'(lat), 32'(5));
      do_read(3, 8'h04, 8'hAA, -1, 8'h00, 4, 8'hBB, lat);
      do_read(3, 8'h04, 8'hBB, -1, 8'h00, -1, 8'h00, lat);
      do_read(3, 8'h06, 8'h77, -1, 8'h00, 2, 8'h77, lat);
      exp_cnt3 += 4;
      @(negedge clk);
      check("cnt_ldtests", 32'(cnt3), 32'(exp_cnt3));

      // Abort: drop read during the second WAIT cycle
      address = 8'h10; rd3 = 1'b1;
      @(posedge clk); @(negedge clk); @(posedge clk); @(negedge clk);
      check("abort_busy_wait", 32'(busy3), 32'(1));
      rd3 = 1'b0;
      lowseen = 0;
      repeat (10) begin
         @(negedge clk);
         if (!wr3) lowseen++;
      end
      check("abort_no_ack", 32'(lowseen), 32'(0));
      check("abort_idle", 32'(busy3), 32'(0));
      check("abort_cnt", 32'(cnt3), 32'(exp_cnt3));
      check("abort_rdata", 32'(rdata3), 32'(8'h77));

      // Reset asserted while in LOAD
      address = 8'h10; rd3 = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("load_busy", 32'(busy3), 32'(1));
      check("load_wr", 32'(wr3), 32'(1));
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_wr", 32'(wr3), 32'(1));
      check("midrst_busy", 32'(busy3), 32'(0));
      check("midrst_cnt", 32'(cnt3), 32'(0));
      check("midrst_rdata", 32'(rdata3), 32'(0));
      rst_n = 1'b1; rd3 = 1'b0;
      exp_cnt3 = 0; exp_cnt0 = 0; exp_cnt7 = 0;
`endif

      // Two-bit counter wraps 3 -> 0
      repeat (5) begin
         do_read(0, 8'h00, 8'hC3, -1, 8'h00, -1, 8'h00, lat);
         exp_cnt0++;
      end
      @(negedge clk);
      check("cnt0_wrap", 32'(cnt0), 32'(exp_cnt0 % 4));

      for (int i = 0; i < 256; i++) ld(8'(i), 8'(i) ^ 8'h5C);
      seen = '0;
      for (int n = 0; n < 200; n++) begin
         a = 8'($urandom_range(0, 255));
         do_read(7, a, a ^ 8'h5C, -1, 8'h00, -1, 8'h00, lat);
         if (lat < 16) seen[lat] = 1'b1;
`ifdef RANDOM_WAIT_EN
         // lat-1 is the ack latency after the sampling edge: 1..8
         check("rand_lat", 32'((lat >= 2) && (lat <= 9)), 32'(1));
`else
         check("w7_lat", 32'(lat), 32'(9));
`endif
         exp_cnt7++;
      end
      @(negedge clk);
      check("cnt7", 32'(cnt7), 32'(exp_cnt7));
`ifdef RANDOM_WAIT_EN
      nlat = 0;
      for (int i = 0; i < 16; i++) nlat += int'(seen[i]);
      check("rand_distinct", 32'(nlat >= 2), 32'(1));
`else
      nlat = 0;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
